mux_n_stream: RTL

//   N-channel, W-bit stream multiplexer with valid/ready handshake and one registered

---
 rtl/mux_n_stream.sv | 134 +++++++++++++
 1 files changed

// File: rtl/mux_n_stream.sv
// mux_n_stream: N-channel valid/ready stream multiplexer.
// Packet-locked grant, external or round-robin select, one output register.
module mux_n_stream #(
  parameter int NUM_CH   = 4,
  parameter int DW       = 8,
  parameter int SEL_W    = $clog2(NUM_CH),
  parameter int ARB_MODE = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NUM_CH*DW-1:0] i_din,
  input  logic [NUM_CH-1:0]    i_valid,
  input  logic [NUM_CH-1:0]    i_last,
  output logic [NUM_CH-1:0]    o_ready,
  input  logic [SEL_W-1:0]     i_sel,
  output logic [DW-1:0]        o_dout,
  output logic                 o_valid,
  output logic                 o_last,
  output logic [SEL_W-1:0]     o_ch,
  input  logic                 i_ready
);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [SEL_W-1:0] lock_q;
  logic [SEL_W-1:0] lock_d;
  logic [SEL_W-1:0] rr_q;
  logic [SEL_W-1:0] rr_d;
  logic [SEL_W-1:0] cur_ch;
  logic [SEL_W-1:0] nxt_ch;
  logic             chan_ok;
  logic             load_en;
  logic             xfer;
  logic             sel_last;
  logic [DW-1:0]    sel_din;

  assign load_en = !o_valid | i_ready;

  // Choose the channel offered a grant this cycle.
  // The round-robin loop runs from the farthest offset down,
  // so the nearest valid channel to rr_q wins.
  always_comb begin
    cur_ch  = '0;
    chan_ok = 1'b0;
    if (state_q == LOCKED) begin
      cur_ch  = lock_q;
      chan_ok = 1'b1;
    end else if (ARB_MODE == 0) begin
      cur_ch  = i_sel;
      chan_ok = (int'(i_sel) < NUM_CH);
    end else begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        for (int k = 0; k < NUM_CH; k++) begin
          if (k == (int'(rr_q) + i) % NUM_CH && i_valid[k]) begin
            cur_ch  = SEL_W'(k);
            chan_ok = 1'b1;
          end
        end
      end
    end
  end

  // One-hot ready and data/last mux for the granted channel.
  // Ready is held low while reset is asserted.
  always_comb begin
    o_ready  = '0;
    sel_din  = '0;
    sel_last = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (cur_ch == SEL_W'(k)) begin
        o_ready[k] = load_en & chan_ok & i_rst_n;
        sel_din    = i_din[k*DW +: DW];
        sel_last   = i_last[k];
      end
    end
  end

  assign xfer   = |(o_ready & i_valid);
  assign nxt_ch = (int'(cur_ch) == NUM_CH - 1) ? '0 : cur_ch + 1'b1;

  // Lock state, locked channel and round-robin pointer next values.
  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    rr_d    = rr_q;
    if (xfer) begin
      if (sel_last) begin
        state_d = IDLE;
        rr_d    = nxt_ch;
      end else if (state_q == IDLE) begin
        state_d = LOCKED;
        lock_d  = cur_ch;
      end
    end
  end

  // Control state registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      lock_q  <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      rr_q    <= rr_d;
    end
  end

  // Output stage: loads on a transfer, drains when downstream takes it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_dout  <= '0;
      o_last  <= 1'b0;
      o_ch    <= '0;
    end else begin
      if (load_en) begin
        o_valid <= xfer;
      end
      if (xfer) begin
        o_dout <= sel_din;
        o_last <= sel_last;
        o_ch   <= cur_ch;
      end
    end
  end

endmodule
